// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops words from a strobe-handshake fifo and shifts them out as async serial frames
module fifo_serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] fifo_q,
    input  logic             fifo_q_ready,
    output logic             fifo_q_out_strobe,
    input  logic             enable,
    output logic             tx,
    output logic             busy
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             stop_q, stop_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             last_bit, last_stop, pop;

    // state, timers, shift register and registered line outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // pop decision, bit sequencing, and the line level for the next cycle
    always_comb begin
        last_bit  = cnt_q == CW'(CLKS_PER_BIT - 1);
        last_stop = state_q == S_STOP && last_bit && stop_q == 1'(STOP_BITS - 1);
        pop       = enable && fifo_q_ready && reset_n && (state_q == S_IDLE || last_stop);
        state_d   = state_q;
        cnt_d     = state_q == S_IDLE ? '0 : cnt_q + CW'(1);
        idx_d     = idx_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        par_d     = par_q;
        if (pop) begin
            state_d = S_START;
            cnt_d   = '0;
            idx_d   = '0;
            stop_d  = 1'b0;
            shift_d = fifo_q;
            par_d   = (^fifo_q) ^ (PARITY == 2);
        end else if (state_q != S_IDLE && last_bit) begin
            cnt_d = '0;
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
                S_DATA: begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IW'(WIDTH - 1)) begin
                        state_d = PARITY != 0 ? S_PARITY : S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                S_PARITY: begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
                S_STOP: begin
                    state_d = stop_q == 1'(STOP_BITS - 1) ? S_IDLE : S_STOP;
                    stop_d  = stop_q + 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = state_d != S_IDLE;
        tx_d   = state_d == S_START  ? 1'b0 :
                 state_d == S_DATA   ? shift_d[0] :
                 state_d == S_PARITY ? par_d : 1'b1;
    end

    assign fifo_q_out_strobe = pop;
    assign tx                = tx_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: three configurations fed from one word stream, each checked cycle-by-cycle against an expected line waveform
module tb_fifo_serial_tx;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] words [256];
    int         wr_n = 0;
    int         errors = 0;
    int         checks = 0;
    logic       done [3];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cfg%0d t=%0t got=%0d expected=%0d", nm, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : blk
        localparam int C = g == 0 ? 4 : g == 1 ? 3 : 2;
        localparam int P = g;
        localparam int S = g == 2 ? 2 : 1;
        logic       tx, busy, strobe, rdy;
        logic [7:0] fq;
        int         rd = 0;
        bit         expq [$];
        bit         e, es;
        logic [7:0] w;

        assign rdy = rd < wr_n;
        assign fq  = words[rd[7:0]];

        fifo_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY(P), .STOP_BITS(S)) dut (
            .clk(clk), .reset_n(reset_n), .fifo_q(fq), .fifo_q_ready(rdy),
            .fifo_q_out_strobe(strobe), .enable(enable), .tx(tx), .busy(busy)
        );

        always @(posedge clk) if (strobe) rd <= rd + 1;

        always @(negedge clk) begin
            if (reset_n) begin
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("tx", g, int'(tx), int'(e));
                    chk("busy", g, int'(busy), 1);
                end else begin
                    chk("tx_idle", g, int'(tx), 1);
                    chk("busy_idle", g, int'(busy), 0);
                end
                es = enable && rd < wr_n && expq.size() == 0;
                chk("strobe", g, int'(strobe), int'(es));
                if (es) begin
                    w = words[rd[7:0]];
                    repeat (C) expq.push_back(1'b0);
                    for (int i = 0; i < 8; i++) repeat (C) expq.push_back(w[i]);
                    if (P != 0) repeat (C) expq.push_back((^w) ^ (P == 2));
                    repeat (C * S) expq.push_back(1'b1);
                end
                done[g] = rd == wr_n && expq.size() == 0;
            end
        end

        always @(negedge reset_n) begin
            #1;
            chk("rst_tx", g, int'(tx), 1);
            chk("rst_busy", g, int'(busy), 0);
            chk("rst_strobe", g, int'(strobe), 0);
            expq.delete();
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] v);
        words[wr_n[7:0]] = v;
        wr_n++;
    endtask

    task automatic drain();
        int t = 0;
        step(2);
        while (!(done[0] && done[1] && done[2]) && t < 5000) begin
            step(1);
            t++;
        end
        chk("drain_timeout", -1, int'(t < 5000), 1);
    endtask

    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        #1 reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(5);
        push(8'hA5);
        step(10);
        enable = 1'b1;
        drain();
        push(8'h00);
        push(8'hFF);
        drain();
        push(8'h07);
        drain();
        push(8'h3C);
        push(8'h5A);
        step(12);
        enable = 1'b0;
        step(100);
        enable = 1'b1;
        drain();
        push(8'hC3);
        push(8'h96);
        step(14);
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        drain();
        for (int k = 0; k < 40; k++) begin
            push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            step($urandom_range(0, 60));
        end
        enable = 1'b1;
        drain();
        step(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
